// File: rtl/md_unit.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// A single radix-2 shift-add / restoring shift-subtract datapath runs n steps, then one sign-fix cycle.
module md_unit #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         wr_hi,
  input  logic         wr_lo,
  input  logic [n-1:0] wdata,
  output logic [n-1:0] hi,
  output logic [n-1:0] lo,
  output logic         busy,
  output logic         done,
  output logic         dbz
);

  localparam int CW = $clog2(n + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic           r_div;
  logic           r_neg_q;
  logic           r_neg_r;
  logic           r_dbz_pend;
  logic [n-1:0]   r_opnd;
  logic [2*n-1:0] r_acc;
  logic [n-1:0]   r_hi;
  logic [n-1:0]   r_lo;
  logic           r_done;
  logic           r_dbz;

  // Operand magnitudes; op[0]=0 selects the signed variants.
  logic         w_signed;
  logic         w_a_neg;
  logic         w_b_neg;
  logic [n-1:0] w_a_mag;
  logic [n-1:0] w_b_mag;

  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & a[n-1];
  assign w_b_neg  = w_signed & b[n-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

  // Multiply: upper half accumulates the multiplicand, carry shifts into bit 2n-1.
  // Divide: (n+1)-bit trial; its MSB is the borrow since the shifted remainder < 2*divisor.
  logic [n:0]     w_sum;
  logic [n:0]     w_trial;
  logic [2*n-1:0] w_prod_fix;
  logic [n-1:0]   w_quo_fix;
  logic [n-1:0]   w_rem_fix;

  assign w_sum      = {1'b0, r_acc[2*n-1:n]} + {1'b0, r_opnd};
  assign w_trial    = r_acc[2*n-1:n-1] - {1'b0, r_opnd};
  assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
  assign w_quo_fix  = r_dbz_pend ? '1 : (r_neg_q ? -r_acc[n-1:0] : r_acc[n-1:0]);
  // With a zero divisor the remainder is |a|; re-applying the dividend sign restores a exactly.
  assign w_rem_fix  = r_neg_r ? -r_acc[2*n-1:n] : r_acc[2*n-1:n];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_cnt == CW'(1)) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_div      <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (wr_hi) r_hi <= wdata;
          if (wr_lo) r_lo <= wdata;
          if (start) begin
            r_div      <= op[1];
            r_cnt      <= CW'(n);
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_dbz_pend <= op[1] && (b == '0);
            r_acc      <= {{n{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
            r_opnd     <= op[1] ? w_b_mag : w_a_mag;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_div) begin
            if (!w_trial[n]) r_acc <= {w_trial[n-1:0], r_acc[n-2:0], 1'b1};
            else             r_acc <= {r_acc[2*n-2:0], 1'b0};
          end else begin
            if (r_acc[0]) r_acc <= {w_sum, r_acc[n-1:1]};
            else          r_acc <= {1'b0, r_acc[2*n-1:1]};
          end
        end
        S_FIX: begin
          if (r_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*n-1:n];
            r_lo <= w_prod_fix[n-1:0];
          end
          r_done <= 1'b1;
          r_dbz  <= r_dbz_pend;
        end
        default: ;
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign dbz  = r_dbz;

endmodule
